// File: rtl/node_result_collector.sv
// rtl/node_result_collector.sv - round-robin collector draining node results into the output memory write port
// Optional stall watchdog enabled by defining COLLECTOR_TIMEOUT_EN.
module node_result_collector #(
    parameter int NUM_NODES      = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ADDR_WIDTH:0]             num_results,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [NUM_NODES-1:0]            req,
    input  logic [NUM_NODES*DATA_WIDTH-1:0] req_data,
    output logic [NUM_NODES-1:0]            grant,
    input  logic                            mem_ready,
    output logic                            mem_wr_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wr_data,
    output logic                            busy,
    output logic                            done
`ifdef COLLECTOR_TIMEOUT_EN
    ,
    output logic                            timeout_err
`endif
);

    localparam int PTR_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [PTR_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic [ADDR_WIDTH:0]   count, count_nxt;
    logic [ADDR_WIDTH:0]   target, target_nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt;

    logic [PTR_W-1:0]      winner;
    logic [PTR_W-1:0]      idx;
    logic                  found;
    logic                  xfer;
    logic                  start_acc;
    logic                  stall_hit;
    logic [DATA_WIDTH-1:0] win_data;

    assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));

    // Rotating priority search starting at rr_ptr; the first requester found wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        if ((state == S_RUN) && mem_ready && (count < target)) begin
            for (int k = 0; k < NUM_NODES; k++) begin
                idx = rr_ptr + PTR_W'(k);
                if (!found && req[idx]) begin
                    found  = 1'b1;
                    winner = idx;
                end
            end
            if (found) begin
                grant[winner] = 1'b1;
            end
        end
    end

    assign xfer     = found;
    assign win_data = req_data[winner*DATA_WIDTH +: DATA_WIDTH];

`ifdef COLLECTOR_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;

    assign stall_hit = (state == S_RUN) && !xfer &&
                       (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else if (start_acc) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else if (state == S_RUN) begin
            if (xfer) begin
                stall_cnt <= '0;
            end else if (stall_hit) begin
                timeout_err <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        count_nxt  = count;
        target_nxt = target;
        base_nxt   = base;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    target_nxt = num_results;
                    base_nxt   = base_addr;
                    count_nxt  = '0;
                    state_nxt  = (num_results == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    count_nxt  = count + (ADDR_WIDTH + 1)'(1);
                    rr_ptr_nxt = winner + PTR_W'(1);
                    if (count_nxt == target) begin
                        state_nxt = S_DONE;
                    end
                end else if (stall_hit) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write port is registered: the winner's data lands one cycle after its grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            count       <= '0;
            target      <= '0;
            base        <= '0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            count     <= count_nxt;
            target    <= target_nxt;
            base      <= base_nxt;
            mem_wr_en <= xfer;
            if (xfer) begin
                mem_addr    <= base + count[ADDR_WIDTH-1:0];
                mem_wr_data <= win_data;
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_node_result_collector.sv
// tb/tb_node_result_collector.sv - randomized self-checking bench for node_result_collector
`timescale 1ns/1ps
module tb_node_result_collector;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW:0]     num_results = '0;
    logic [AW-1:0]   base_addr = '0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    grant;
    logic            mem_ready = 1'b0;
    logic            mem_wr_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wr_data;
    logic            busy;
    logic            done;
`ifdef COLLECTOR_TIMEOUT_EN
    logic            timeout_err;
`endif

    int vectors = 0;
    int fails   = 0;

    // Reference model: 0=idle, 1=run, 2=done
    int            m_state, m_rr, m_count, m_target, m_base, m_stall, m_writes;
    logic          m_wr, m_terr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    node_result_collector #(
        .NUM_NODES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_results(num_results),
        .base_addr(base_addr), .req(req), .req_data(req_data), .grant(grant),
        .mem_ready(mem_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .busy(busy), .done(done)
`ifdef COLLECTOR_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_rr = 0; m_count = 0; m_target = 0; m_base = 0; m_stall = 0;
        m_wr = 1'b0; m_terr = 1'b0; m_addr = '0; m_data = '0;
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_state == 1 && mem_ready && m_count < m_target) begin
            for (int k = 0; k < N; k++) begin
                if (g == '0 && req[(m_rr + k) % N]) g[(m_rr + k) % N] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_edge(input logic [N-1:0] g);
        int w;
        m_wr = 1'b0;
        if (start && m_state != 1) begin
            m_target = int'(num_results); m_base = int'(base_addr);
            m_count = 0; m_stall = 0; m_terr = 1'b0;
            m_state = (num_results == 0) ? 2 : 1;
        end else if (m_state == 1) begin
            if (g != '0) begin
                w = 0;
                for (int i = 0; i < N; i++) if (g[i]) w = i;
                m_wr = 1'b1;
                m_addr = AW'((m_base + m_count) % (1 << AW));
                m_data = req_data[w*DW +: DW];
                m_count++; m_writes++; m_stall = 0;
                m_rr = (w + 1) % N;
                if (m_count == m_target) m_state = 2;
            end else begin
                m_stall++;
`ifdef COLLECTOR_TIMEOUT_EN
                if (m_stall == TO) begin m_terr = 1'b1; m_state = 2; end
`endif
            end
        end
    endtask

    task automatic tick();
        model_edge(model_grant());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req = '1; mem_ready = 1'b1; start = 1'b1; num_results = 9'd4;
        @(posedge clk); #1;
        vectors++;
        if ({grant, mem_wr_en, mem_addr, mem_wr_data, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_hold: got grant=%b wr=%b addr=%h data=%h busy=%b done=%b, want all zero",
                     grant, mem_wr_en, mem_addr, mem_wr_data, busy, done);
        end
        start = 1'b0; rst = 1'b0; model_reset();
        tick();
        vectors++;
        if ({grant, mem_wr_en, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_idle: got grant=%b wr=%b busy=%b done=%b, want 0",
                     grant, mem_wr_en, busy, done);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
        base_addr = 8'h10; num_results = 9'd8; mem_ready = 1'b1; req = '1; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_g = model_grant();
            vectors++;
            if (grant !== exp_g || grant !== N'(1 << (k % N))) begin
                fails++;
                $display("FAIL rr_grant k=%0d: got %b, want %b", k, grant, N'(1 << (k % N)));
            end
            tick();
            vectors++;
            if (mem_wr_en !== 1'b1 || mem_addr !== AW'(8'h10 + k) ||
                mem_wr_data !== req_data[(k % N)*DW +: DW] ||
                busy !== (m_state == 1) || done !== (m_state == 2)) begin
                fails++;
                $display("FAIL rr_write k=%0d: got wr=%b addr=%h data=%h busy=%b done=%b, want wr=1 addr=%h data=%h busy=%b done=%b",
                         k, mem_wr_en, mem_addr, mem_wr_data, busy, done, AW'(8'h10 + k),
                         req_data[(k % N)*DW +: DW], m_state == 1, m_state == 2);
            end
        end
        #1;
        vectors++;
        if (grant !== '0 || done !== 1'b1) begin
            fails++;
            $display("FAIL rr_after: got grant=%b done=%b, want grant=0 done=1", grant, done);
        end
    endtask

    task automatic test_zero_count();
        req = '1; mem_ready = 1'b1; num_results = '0; base_addr = 8'h33; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (grant !== '0 || mem_wr_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL zero_count k=%0d: got grant=%b wr=%b busy=%b done=%b, want 0,0,0,1",
                         k, grant, mem_wr_en, busy, done);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] exp_g;
        int dut_writes;
        dut_writes = 0; m_writes = 0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
        req = '1; mem_ready = 1'b1; num_results = 9'd4; base_addr = AW'($urandom); start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            mem_ready = !(k >= 2 && k <= 4);
            #1;
            exp_g = model_grant();
            vectors++;
            if (grant !== exp_g) begin
                fails++;
                $display("FAIL bp_grant k=%0d: got %b, want %b", k, grant, exp_g);
            end
            tick();
            dut_writes += int'(mem_wr_en);
            vectors++;
            if (mem_wr_en !== m_wr || mem_addr !== m_addr || mem_wr_data !== m_data ||
                busy !== (m_state == 1) || done !== (m_state == 2)) begin
                fails++;
                $display("FAIL bp_out k=%0d: got wr=%b addr=%h data=%h busy=%b done=%b, want wr=%b addr=%h data=%h busy=%b done=%b",
                         k, mem_wr_en, mem_addr, mem_wr_data, busy, done,
                         m_wr, m_addr, m_data, m_state == 1, m_state == 2);
            end
        end
        vectors++;
        if (dut_writes !== 4 || m_writes != 4) begin
            fails++;
            $display("FAIL bp_total: got %0d writes, want 4", dut_writes);
        end
    endtask

    task automatic test_wrap_sparse();
        logic [AW-1:0] exp_addr [3];
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00;
        req_data[2*DW +: DW] = DW'($urandom);
        req = 4'b0100; mem_ready = 1'b1; num_results = 9'd3; base_addr = 8'hFE; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (grant !== 4'b0100 || grant !== model_grant()) begin
                fails++;
                $display("FAIL wrap_grant k=%0d: got %b, want 0100", k, grant);
            end
            tick();
            vectors++;
            if (mem_wr_en !== 1'b1 || mem_addr !== exp_addr[k] || mem_wr_data !== req_data[2*DW +: DW]) begin
                fails++;
                $display("FAIL wrap_write k=%0d: got wr=%b addr=%h data=%h, want wr=1 addr=%h data=%h",
                         k, mem_wr_en, mem_addr, mem_wr_data, exp_addr[k], req_data[2*DW +: DW]);
            end
        end
        vectors++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL wrap_done: got %b, want 1", done);
        end
    endtask

    task automatic test_control();
        req = '1; mem_ready = 1'b1; num_results = 9'd10; base_addr = 8'h40; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        start = 1'b1; num_results = 9'd1; base_addr = 8'h80;
        tick(); start = 1'b0;
        vectors++;
        if (mem_wr_en !== m_wr || mem_addr !== m_addr || busy !== 1'b1 || m_state != 1) begin
            fails++;
            $display("FAIL ctl_start_in_run: got wr=%b addr=%h busy=%b, want wr=%b addr=%h busy=1",
                     mem_wr_en, mem_addr, busy, m_wr, m_addr);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({grant, mem_wr_en, mem_addr, mem_wr_data, busy, done} !== '0) begin
            fails++;
            $display("FAIL ctl_async_rst: got grant=%b wr=%b addr=%h data=%h busy=%b done=%b, want all zero",
                     grant, mem_wr_en, mem_addr, mem_wr_data, busy, done);
        end
        #2; rst = 1'b0; model_reset();
        @(posedge clk); #1;
        num_results = 9'd2; base_addr = 8'h20; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (mem_wr_en !== m_wr || mem_addr !== m_addr || mem_wr_data !== m_data || done !== (m_state == 2)) begin
                fails++;
                $display("FAIL ctl_restart k=%0d: got wr=%b addr=%h data=%h done=%b, want wr=%b addr=%h data=%h done=%b",
                         k, mem_wr_en, mem_addr, mem_wr_data, done, m_wr, m_addr, m_data, m_state == 2);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_g, held;
        int guard;
        for (int run = 0; run < 6; run++) begin
            num_results = (AW+1)'($urandom_range(1, 24));
            base_addr = AW'($urandom);
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
            req = N'($urandom); mem_ready = 1'b1; start = 1'b1;
            tick(); start = 1'b0;
            guard = 0;
            while (m_state == 1 && guard < 300) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                #1;
                exp_g = model_grant();
                vectors++;
                if (grant !== exp_g) begin
                    fails++;
                    $display("FAIL rnd_grant run=%0d cyc=%0d: got %b, want %b", run, guard, grant, exp_g);
                end
                held = req & ~exp_g;
                tick();
                vectors++;
                if (mem_wr_en !== m_wr || mem_addr !== m_addr || mem_wr_data !== m_data ||
                    busy !== (m_state == 1) || done !== (m_state == 2)) begin
                    fails++;
                    $display("FAIL rnd_out run=%0d cyc=%0d: got wr=%b addr=%h data=%h busy=%b done=%b, want wr=%b addr=%h data=%h busy=%b done=%b",
                             run, guard, mem_wr_en, mem_addr, mem_wr_data, busy, done,
                             m_wr, m_addr, m_data, m_state == 1, m_state == 2);
                end
                for (int i = 0; i < N; i++) begin
                    if (!held[i]) begin
                        req[i] = 1'($urandom);
                        req_data[i*DW +: DW] = DW'($urandom);
                    end
                end
                guard++;
            end
            vectors++;
            if (m_state != 2 || done !== 1'b1) begin
                fails++;
                $display("FAIL rnd_complete run=%0d: got done=%b, want 1 within 300 cycles", run, done);
            end
        end
    endtask

`ifdef COLLECTOR_TIMEOUT_EN
    task automatic test_timeout();
        int dut_writes;
        dut_writes = 0;
        req = 4'b0001; mem_ready = 1'b1; num_results = 9'd2; base_addr = 8'h00; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < TO + 3; k++) begin
            #1;
            tick();
            req = '0;
            dut_writes += int'(mem_wr_en);
            vectors++;
            if (timeout_err !== m_terr || done !== (m_state == 2) || mem_wr_en !== m_wr) begin
                fails++;
                $display("FAIL to_cycle k=%0d: got terr=%b done=%b wr=%b, want terr=%b done=%b wr=%b",
                         k, timeout_err, done, mem_wr_en, m_terr, m_state == 2, m_wr);
            end
        end
        vectors++;
        if (timeout_err !== 1'b1 || done !== 1'b1 || dut_writes !== 1) begin
            fails++;
            $display("FAIL to_final: got terr=%b done=%b writes=%0d, want 1,1,1", timeout_err, done, dut_writes);
        end
    endtask
`endif

    initial begin
        model_reset();
        m_writes = 0;
        test_reset();
        test_round_robin();
        test_zero_count();
        test_backpressure();
        test_wrap_sparse();
        test_control();
        test_random();
`ifdef COLLECTOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
